// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero insertion, FCS and abort on a serial line.
// Define TX_FCS_EN to build in the CRC-16 FCS generator and FCS state.
module hdlc_tx_framer (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_DataValid,
  input  logic       Tx_DataLast,
  output logic       Tx_DataReady,
  input  logic       Tx_AbortFrame,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_FLAG = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
`ifdef TX_FCS_EN
  localparam logic [2:0] FCS        = 3'd3;
`endif
  localparam logic [2:0] END_FLAG   = 3'd4;
  localparam logic [2:0] ABORT      = 3'd5;

  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ABRT = 8'hFE;

  logic [2:0] state;
  logic [4:0] cnt;
  logic [7:0] shreg;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       hold_last;
  logic       cur_last;
  logic       abort_req;
  logic [2:0] ones;

  logic wr;
  logic in_body;
  logic honour;
  logic stuff;
  logic boundary;

`ifdef TX_FCS_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    crc_step = (c >> 1) ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction

  assign in_body = (state == DATA) || (state == FCS);
  assign honour  = (state == START_FLAG) || in_body;
`else
  assign in_body = (state == DATA);
  assign honour  = (state == START_FLAG) || in_body;
`endif

  assign wr    = Tx_DataValid && Tx_DataReady;
  assign stuff = in_body && (ones == 3'd5);

  // Points where the next payload byte must be taken from the holding register
  assign boundary =
    ((state == START_FLAG) && (cnt == 5'd8)) ||
    ((state == DATA) && !stuff &&
     (cnt == 5'd8) && !cur_last);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      hold_data       <= '0;
      hold_full       <= 1'b0;
      hold_last       <= 1'b0;
      cur_last        <= 1'b0;
      abort_req       <= 1'b0;
      ones            <= '0;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_DataReady    <= 1'b1;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
`ifdef TX_FCS_EN
      crc             <= 16'hFFFF;
`endif
    end else begin
      Tx_Done      <= 1'b0;
      Tx_DataReady <= !hold_full && !wr;
      abort_req    <= Tx_AbortFrame && honour;
      if (abort_req && (state != ABORT)) begin
        state     <= ABORT;
        Tx        <= ABRT[0];
        cnt       <= 5'd1;
        hold_full <= 1'b0;
      end else if (boundary) begin
        if (hold_full) begin
          state     <= DATA;
          Tx        <= hold_data[0];
          shreg     <= {1'b0, hold_data[7:1]};
          cur_last  <= hold_last;
          hold_full <= 1'b0;
          cnt       <= 5'd1;
          ones      <= hold_data[0] ? ones + 3'd1 : 3'd0;
`ifdef TX_FCS_EN
          crc       <= crc_step(crc, hold_data[0]);
`endif
        end else begin
          state <= ABORT;
          Tx    <= ABRT[0];
          cnt   <= 5'd1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            Tx <= 1'b1;
            if (hold_full) begin
              state           <= START_FLAG;
              Tx              <= FLAG[0];
              cnt             <= 5'd1;
              ones            <= 3'd0;
              Tx_ValidFrame   <= 1'b1;
              Tx_AbortedTrans <= 1'b0;
`ifdef TX_FCS_EN
              crc             <= 16'hFFFF;
`endif
            end
          end
          START_FLAG: begin
            Tx  <= FLAG[cnt[2:0]];
            cnt <= cnt + 5'd1;
          end
          DATA: begin
            if (stuff) begin
              Tx   <= 1'b0;
              ones <= 3'd0;
            end else if (cnt != 5'd8) begin
              Tx    <= shreg[0];
              shreg <= shreg >> 1;
              cnt   <= cnt + 5'd1;
              ones  <= shreg[0] ? ones + 3'd1 : 3'd0;
`ifdef TX_FCS_EN
              crc   <= crc_step(crc, shreg[0]);
`endif
            end else begin
`ifdef TX_FCS_EN
              state <= FCS;
              Tx    <= ~crc[0];
              crc   <= {1'b1, crc[15:1]};
              cnt   <= 5'd1;
              ones  <= !crc[0] ? ones + 3'd1 : 3'd0;
`else
              state <= END_FLAG;
              Tx    <= FLAG[0];
              cnt   <= 5'd1;
`endif
            end
          end
`ifdef TX_FCS_EN
          FCS: begin
            if (stuff) begin
              Tx   <= 1'b0;
              ones <= 3'd0;
            end else if (cnt != 5'd16) begin
              Tx   <= ~crc[0];
              crc  <= {1'b1, crc[15:1]};
              cnt  <= cnt + 5'd1;
              ones <= !crc[0] ? ones + 3'd1 : 3'd0;
            end else begin
              state <= END_FLAG;
              Tx    <= FLAG[0];
              cnt   <= 5'd1;
            end
          end
`endif
          END_FLAG: begin
            if (cnt != 5'd8) begin
              Tx  <= FLAG[cnt[2:0]];
              cnt <= cnt + 5'd1;
            end else begin
              state         <= IDLE;
              Tx            <= 1'b1;
              Tx_ValidFrame <= 1'b0;
              Tx_Done       <= 1'b1;
            end
          end
          ABORT: begin
            Tx_AbortedTrans <= 1'b1;
            if (cnt != 5'd8) begin
              Tx  <= ABRT[cnt[2:0]];
              cnt <= cnt + 5'd1;
            end else begin
              state         <= IDLE;
              Tx            <= 1'b1;
              Tx_ValidFrame <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (wr) begin
        hold_data <= Tx_Data;
        hold_last <= Tx_DataLast;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: frame table plus abort/underrun/reset cases.
// FCS expectations are included when TX_FCS_EN is defined.
module tb_hdlc_tx_framer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_DataValid = 1'b0;
  logic       Tx_DataLast = 1'b0;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx_DataReady;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  int tests = 0;
  int fails = 0;

`ifdef TX_FCS_EN
  localparam int NFCS = 16;
`else
  localparam int NFCS = 0;
`endif

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Tx_Data        (Tx_Data),
    .Tx_DataValid   (Tx_DataValid),
    .Tx_DataLast    (Tx_DataLast),
    .Tx_DataReady   (Tx_DataReady),
    .Tx_AbortFrame  (Tx_AbortFrame),
    .Tx             (Tx),
    .Tx_ValidFrame  (Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx_Done        (Tx_Done)
  );

  typedef struct {
    int          nb;
    logic [71:0] data;
    int          explen;
    logic [79:0] expbits;
    logic [15:0] fcs;
    bit          fcs_known;
  } frame_t;

  frame_t tbl [7];

  logic cap_tx [$];
  logic cap_vf [$];
  logic cap_dn [$];
  logic cap_ab [$];
  logic cap_rd [$];

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef TX_FCS_EN
  function automatic logic [15:0] x25(input logic [71:0] d, input int nb);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 8 * nb; i++)
      c = (c >> 1) ^ ((c[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    return ~c;
  endfunction
`endif

  // cap_* index c holds the outputs sampled just after edge c of the run
  task automatic run(input int nb, input logic [71:0] data, input bit nolast,
                     input int abort_at, input int rst_at, input int cycles);
    int idx;
    int k;
    bit pend;
    bit stop;
    idx  = 0;
    stop = 1'b0;
    cap_tx.delete();
    cap_vf.delete();
    cap_dn.delete();
    cap_ab.delete();
    cap_rd.delete();
    for (int c = 0; c < cycles; c++) begin
      if (c == abort_at || c == rst_at) stop = 1'b1;
      k = (idx < nb) ? idx : 0;
      Tx_DataValid  = !stop && (idx < nb);
      Tx_Data       = data[8*k +: 8];
      Tx_DataLast   = (idx == nb - 1) && !nolast;
      Tx_AbortFrame = (c == abort_at);
      Rst           = (c == rst_at);
      pend = Tx_DataValid && Tx_DataReady;
      @(posedge Clk);
      #1;
      if (pend) idx++;
      cap_tx.push_back(Tx);
      cap_vf.push_back(Tx_ValidFrame);
      cap_dn.push_back(Tx_Done);
      cap_ab.push_back(Tx_AbortedTrans);
      cap_rd.push_back(Tx_DataReady);
    end
    Tx_DataValid  = 1'b0;
    Tx_DataLast   = 1'b0;
    Tx_AbortFrame = 1'b0;
    Rst           = 1'b0;
  endtask

  task automatic check_frame(input int t, input bit chk_ab);
    int s, p, pos, ones, got, need, dn_cnt, dn_at, vf_cnt, ab_cnt, sterr;
    logic [79:0] raw;
    logic [7:0]  fl;
    string tag;
`ifdef TX_FCS_EN
    logic [87:0] ub;
    logic [15:0] fg, fe;
    ub = '0;
`endif
    tag = $sformatf("f%0d", t);
    s = -1;
    for (int i = 0; i < cap_vf.size(); i++)
      if (s < 0 && cap_vf[i] === 1'b1) s = i;
    check({tag, "_start"}, s, 1);
    if (s < 0) s = 1;
    p = s + 8;
    for (int i = 0; i < 8; i++) fl[i] = cap_tx[s+i];
    check({tag, "_open_flag"}, fl, 8'h7E);
    check({tag, "_rdy_k9"}, cap_rd[9], 0);
    check({tag, "_rdy_k10"}, cap_rd[10], 1);
    raw = '0;
    for (int i = 0; i < tbl[t].explen; i++) raw[i] = cap_tx[p+i];
    check({tag, "_data"}, raw, tbl[t].expbits);
    need  = 8 * tbl[t].nb + NFCS;
    ones  = 0;
    got   = 0;
    sterr = 0;
    pos   = p;
    while (got < need && pos < cap_tx.size() - 9) begin
      if (ones == 5) begin
        if (cap_tx[pos] !== 1'b0) sterr++;
        ones = 0;
      end else begin
`ifdef TX_FCS_EN
        ub[got] = cap_tx[pos];
`endif
        got++;
        ones = (cap_tx[pos] === 1'b1) ? ones + 1 : 0;
      end
      pos++;
    end
    if (ones == 5) begin
      if (cap_tx[pos] !== 1'b0) sterr++;
      pos++;
    end
    check({tag, "_stuff0"}, sterr, 0);
`ifdef TX_FCS_EN
    fg = ub[8*tbl[t].nb +: 16];
    fe = tbl[t].fcs_known ? tbl[t].fcs : x25(tbl[t].data, tbl[t].nb);
    check({tag, "_fcs"}, fg, fe);
`else
    check({tag, "_data_end"}, pos, p + tbl[t].explen);
`endif
    for (int i = 0; i < 8; i++) fl[i] = cap_tx[pos+i];
    check({tag, "_close_flag"}, fl, 8'h7E);
    dn_cnt = 0;
    dn_at  = -1;
    vf_cnt = 0;
    ab_cnt = 0;
    for (int i = 0; i < cap_dn.size(); i++) begin
      if (cap_dn[i] === 1'b1) begin
        dn_cnt++;
        if (dn_at < 0) dn_at = i;
      end
      if (cap_vf[i] === 1'b1) vf_cnt++;
      if (cap_ab[i] !== 1'b0) ab_cnt++;
    end
    check({tag, "_done_cnt"}, dn_cnt, 1);
    check({tag, "_done_at"}, dn_at, pos + 8);
    check({tag, "_vf_span"}, vf_cnt, pos + 8 - s);
    check({tag, "_tx_after"}, cap_tx[pos+8], 1);
    if (chk_ab) check({tag, "_aborted"}, ab_cnt, 0);
  endtask

  task automatic check_abort(input string tag, input int k, input int n);
    logic [7:0] fl;
    int bad;
    for (int i = 0; i < 8; i++) fl[i] = cap_tx[k+i];
    check({tag, "_pattern"}, fl, 8'hFE);
    check({tag, "_sticky_k1"}, cap_ab[k], 0);
    check({tag, "_sticky_k2"}, cap_ab[k+1], 1);
    check({tag, "_vf_k8"}, cap_vf[k+7], 1);
    check({tag, "_vf_k9"}, cap_vf[k+8], 0);
    bad = 0;
    for (int i = k + 8; i < n; i++)
      if (cap_tx[i] !== 1'b1 || cap_vf[i] !== 1'b0) bad++;
    check({tag, "_quiet"}, bad, 0);
    bad = 0;
    for (int i = 0; i < n; i++) if (cap_dn[i] !== 1'b0) bad++;
    check({tag, "_no_done"}, bad, 0);
    check({tag, "_ready_end"}, cap_rd[n-1], 1);
  endtask

  initial begin
    int bad;
    tbl[0] = '{1, 72'h00, 8, 80'h00, 16'h0000, 1'b0};
    tbl[1] = '{2, 72'h01FF, 17, 80'h3DF, 16'h0000, 1'b0};
    tbl[2] = '{1, 72'h7E, 9, 80'hBE, 16'h0000, 1'b0};
    tbl[3] = '{1, 72'hAA, 8, 80'hAA, 16'h0000, 1'b0};
    tbl[4] = '{2, 72'h0FF0, 17, 80'h1DF0, 16'h0000, 1'b0};
    tbl[5] = '{1, 72'hF8, 9, 80'hF8, 16'h0000, 1'b0};
    tbl[6] = '{9, 72'h393837363534333231, 72,
               80'h393837363534333231, 16'h906E, 1'b1};

    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_tx", Tx, 1);
    check("rst_vf", Tx_ValidFrame, 0);
    check("rst_ready", Tx_DataReady, 1);
    check("rst_aborted", Tx_AbortedTrans, 0);
    check("rst_done", Tx_Done, 0);
    Rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (Tx !== 1'b1 || Tx_ValidFrame !== 1'b0 || Tx_DataReady !== 1'b1)
        bad++;
    end
    check("idle20", bad, 0);

    for (int t = 0; t < 7; t++) begin
      run(tbl[t].nb, tbl[t].data, 1'b0, -1, -1, 130);
      check_frame(t, 1'b1);
    end

    run(1, 72'h00, 1'b1, -1, -1, 50);
    check_abort("underrun", 17, 50);

    run(4, 72'h0000FF00, 1'b0, 20, -1, 50);
    check("abort_cur_bit", cap_tx[20], 1);
    check_abort("abort", 21, 50);

    run(1, 72'h00, 1'b0, -1, -1, 130);
    check("clear_before", cap_ab[0], 1);
    check("clear_at_start", cap_ab[1], 0);
    check_frame(0, 1'b0);

    run(2, 72'h0000, 1'b0, -1, 12, 40);
    check("mrst_vf_before", cap_vf[11], 1);
    check("mrst_tx", cap_tx[12], 1);
    check("mrst_vf", cap_vf[12], 0);
    check("mrst_ready", cap_rd[12], 1);
    bad = 0;
    for (int i = 12; i < 40; i++)
      if (cap_tx[i] !== 1'b1 || cap_vf[i] !== 1'b0) bad++;
    check("mrst_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
